lsu_load_unit: RTL and testbench
================================

# lsu_load_unit

Response-side companion to the LSU request stage: tracks the single outstanding data-memory transaction, waits for grant and read-valid, then extracts, aligns and sign/zero-extends load data for register-file writeback. Sits between the data-memory interface (`data_gnt_i`, `data_rvalid_i`, `data_rdata_i`) and the core writeback mux. Drives a busy/stall signal back to the core while a transaction is in flight.

## Interface
- `TIMEOUT_CYCLES`, default 255: watchdog limit in cycles. Used only with `LSU_LOAD_TIMEOUT_EN`. Legal range 1..65535.
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid_i`  in  1  core issued a memory op this cycle. Same cycle the request stage samples it.
- `req_we_i`  in  1  1 = store, 0 = load
- `req_size_i`  in  2  01 = byte, 10 = half, 11 = word, 00 = no op (ignored)
- `req_unsigned_i`  in  1  1 = zero-extend (LBU/LHU), 0 = sign-extend
- `req_offset_i`  in  2  data address bits [1:0]
- `req_rd_i`  in  5  destination register
- `data_gnt_i`  in  1  memory grant
- `data_rvalid_i`  in  1  memory response valid
- `data_rdata_i`  in  32  memory read word (word-aligned lanes)
- `busy_o`  out  1  transaction in flight; core must stall
- `wb_valid_o`  out  1  one-cycle writeback strobe
- `wb_rd_o`  out  5  writeback register
- `wb_data_o`  out  32  aligned, extended load data
- `err_o`  out  1  one-cycle timeout strobe

## Operation
- FSM states: IDLE, WAIT_GNT, WAIT_RVALID.
- IDLE → WAIT_GNT when `req_valid_i`=1 and `req_size_i`≠00.
  - Latches we, size, unsigned, offset and rd into context registers.
  - Requests arriving in any other state are ignored. Holding them off via `busy_o` is the core's job.
- WAIT_GNT → WAIT_RVALID on `data_gnt_i`=1. `data_rvalid_i` is ignored in WAIT_GNT.
- WAIT_RVALID → IDLE on `data_rvalid_i`=1.
  - Load: `wb_valid_o`=1 for one cycle with extracted data.
  - Store: no strobe; `data_rdata_i` is discarded.
- Extraction uses the latched offset:
  - Byte: lane = rdata[8·off+7 : 8·off]; bit 7 of the lane is the sign bit.
  - Half: off[1]=0 → rdata[15:0], off[1]=1 → rdata[31:16]; bit 15 of the lane is the sign bit. off[0] is ignored.
  - Word: rdata unchanged; unsigned flag ignored.
- `busy_o` is combinational: 1 in WAIT_GNT or WAIT_RVALID, and also in IDLE while `req_valid_i` is being accepted.

## Timing
- Reset values: state IDLE; `wb_valid_o`, `wb_rd_o`, `wb_data_o`, `err_o` and all context registers 0. `busy_o` is 0 unless `req_valid_i` is 1.
- Earliest grant is cycle N+1 after acceptance in cycle N; earliest rvalid is the cycle after the grant.
- Writeback latency: `wb_valid_o` rises the cycle after `data_rvalid_i` is sampled. Minimum load-to-writeback is 3 cycles after `req_valid_i`.
- `wb_rd_o`/`wb_data_o` are registered and hold their value until the next writeback (or timeout clear).
- A new request is accepted in the same cycle `wb_valid_o` is high (state is already IDLE).
- Reset asserted mid-transaction: immediate return to IDLE, no writeback, no `err_o`. A late `data_rvalid_i` arriving in IDLE is ignored.

## Configuration
- Macro `LSU_LOAD_TIMEOUT_EN` defined:
  - 16-bit counter clears on entry to WAIT_GNT and increments every cycle in WAIT_GNT/WAIT_RVALID.
  - When count = `TIMEOUT_CYCLES` without completion: `err_o`=1 for one cycle, FSM → IDLE, no writeback, `wb_data_o` unchanged.
  - A grant or rvalid in the same cycle as expiry takes priority; no error.
- Not defined: no counter, `err_o` tied 0, FSM waits indefinitely.

## Test plan
- LB, offset 2, rdata 0x12_80_56_78: gnt +1, rvalid +1 → `wb_data_o`=0xFFFF_FF80, `wb_rd_o` as issued, one-cycle `wb_valid_o`.
- LHU, offset 2, rdata 0x8001_1234 → 0x0000_8001. LH, offset 0, rdata 0x0000_F00F → 0xFFFF_F00F.
- SW with gnt delayed 3 cycles, rvalid delayed 2 more → `busy_o` high 6 cycles, no `wb_valid_o`. A second `req_valid_i` mid-flight is ignored.
- Back-to-back: LW completes (rdata 0xDEADBEEF), next LW accepted in the `wb_valid_o` cycle → two strobes, correct data each.
- `rst_n` low while in WAIT_RVALID, then rvalid pulse after release → no `wb_valid_o`; all outputs at reset values.
- With `LSU_LOAD_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, no grant → `err_o` pulses on cycle 8, `busy_o` drops, next request accepted normally. Without the macro, same stimulus → `busy_o` stays high, `err_o`=0.

Source files
------------

// File: rtl/lsu_load_unit_if.sv
// Bus bundle for lsu_load_unit: core request, data-memory response and writeback.
// slave = the load unit itself, master = the core/memory side driving it.
interface lsu_load_unit_if;
  logic        req_valid_i;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [1:0]  req_offset_i;
  logic [4:0]  req_rd_i;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic        busy_o;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        err_o;

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_offset_i, req_rd_i,
    input  data_gnt_i, data_rvalid_i, data_rdata_i,
    output busy_o, wb_valid_o, wb_rd_o, wb_data_o, err_o
  );

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_offset_i, req_rd_i,
    output data_gnt_i, data_rvalid_i, data_rdata_i,
    input  busy_o, wb_valid_o, wb_rd_o, wb_data_o, err_o
  );
endinterface

// File: rtl/lsu_load_unit.sv
// LSU load unit: tracks one outstanding data-memory transaction and produces the
// aligned, sign/zero-extended load writeback.
// Optional watchdog enabled by defining LSU_LOAD_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module lsu_load_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic           clk,
  input logic           rst_n,
  lsu_load_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StWaitGnt, StWaitRvalid} state_e;

  state_e      state_q, state_d;
  logic        we_q, unsigned_q;
  logic [1:0]  size_q, offset_q;
  logic [4:0]  rd_q;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        err_q, err_d;
  logic        accept;
  logic        expire;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;

  // Size 00 is a no-op and never starts a transaction.
  assign accept = (state_q == StIdle) && bus.req_valid_i && (bus.req_size_i != 2'b00);

`ifdef LSU_LOAD_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  // Watchdog counter: cleared on acceptance, counts every cycle spent waiting.
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = '0;
    end else if (state_q != StIdle) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expires on the TIMEOUT_CYCLES-th waiting cycle.
  assign expire = (state_q != StIdle) && (cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT_CYCLES);
  assign expire         = 1'b0;
`endif

  // Lane extraction and extension from the latched request context.
  always_comb begin
    byte_lane = bus.data_rdata_i[7:0];
    unique case (offset_q)
      2'd0: byte_lane = bus.data_rdata_i[7:0];
      2'd1: byte_lane = bus.data_rdata_i[15:8];
      2'd2: byte_lane = bus.data_rdata_i[23:16];
      2'd3: byte_lane = bus.data_rdata_i[31:24];
      default: byte_lane = bus.data_rdata_i[7:0];
    endcase
    half_lane = offset_q[1] ? bus.data_rdata_i[31:16] : bus.data_rdata_i[15:0];
    unique case (size_q)
      2'b01:   load_data = {{24{~unsigned_q & byte_lane[7]}}, byte_lane};
      2'b10:   load_data = {{16{~unsigned_q & half_lane[15]}}, half_lane};
      default: load_data = bus.data_rdata_i;
    endcase
  end

  // Next-state and writeback/error strobes; progress beats watchdog expiry.
  always_comb begin
    state_d    = state_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    err_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StWaitGnt;
      end
      StWaitGnt: begin
        if (bus.data_gnt_i) begin
          state_d = StWaitRvalid;
        end else if (expire) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
      end
      StWaitRvalid: begin
        if (bus.data_rvalid_i) begin
          state_d = StIdle;
          if (!we_q) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = load_data;
          end
        end else if (expire) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, request context and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= 2'b00;
      offset_q   <= 2'b00;
      rd_q       <= 5'd0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
      if (accept) begin
        we_q       <= bus.req_we_i;
        unsigned_q <= bus.req_unsigned_i;
        size_q     <= bus.req_size_i;
        offset_q   <= bus.req_offset_i;
        rd_q       <= bus.req_rd_i;
      end
    end
  end

  assign bus.busy_o     = (state_q != StIdle) || accept;
  assign bus.wb_valid_o = wb_valid_q;
  assign bus.wb_rd_o    = wb_rd_q;
  assign bus.wb_data_o  = wb_data_q;
  assign bus.err_o      = err_q;

endmodule

// File: tb/tb_lsu_load_unit.sv
// Self-checking bench for lsu_load_unit: directed loads/stores, reset abort,
// watchdog behaviour and a randomized transaction stream against a reference model.
module tb_lsu_load_unit;
  localparam int unsigned TimeoutCycles = 8;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // Model of the last writeback (registered outputs hold between strobes).
  logic [4:0]  exp_rd   = 5'd0;
  logic [31:0] exp_data = 32'd0;

  lsu_load_unit_if bus ();

  lsu_load_unit #(
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Load result from the byte/half/word rules with plain arithmetic.
  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                             input logic [1:0] off, input logic [31:0] rdata);
    int unsigned width;
    int unsigned val;
    if (size == 2'b11) return rdata;
    width = (size == 2'b01) ? 8 : 16;
    if (width == 8) val = (rdata >> (8 * off)) & 32'hFF;
    else            val = (rdata >> (16 * (off / 2))) & 32'hFFFF;
    if (!uns && ((val >> (width - 1)) != 0)) val = val - (32'd1 << width);
    return val;
  endfunction

  task automatic idle_inputs();
    bus.req_valid_i    = 1'b0;
    bus.req_we_i       = 1'b0;
    bus.req_size_i     = 2'b00;
    bus.req_unsigned_i = 1'b0;
    bus.req_offset_i   = 2'b00;
    bus.req_rd_i       = 5'd0;
    bus.data_gnt_i     = 1'b0;
    bus.data_rvalid_i  = 1'b0;
    bus.data_rdata_i   = 32'd0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wb_valid"}, 32'(bus.wb_valid_o), 32'd0);
    check({tag, "_wb_rd"}, 32'(bus.wb_rd_o), 32'(exp_rd));
    check({tag, "_wb_data"}, bus.wb_data_o, exp_data);
    check({tag, "_err"}, 32'(bus.err_o), 32'd0);
  endtask

  // One full transaction, started just after a falling edge; ends just after the
  // falling edge where the writeback (if any) is visible.
  task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                     input logic [1:0] off, input logic [4:0] rd, input logic [31:0] rdata,
                     input int gd, input int rdly, input logic spurious);
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = we;
    bus.req_size_i     = size;
    bus.req_unsigned_i = uns;
    bus.req_offset_i   = off;
    bus.req_rd_i       = rd;
    #1 check("busy_accept", 32'(bus.busy_o), 32'd1);
    @(negedge clk);
    // A request while busy must be ignored.
    bus.req_valid_i    = spurious;
    bus.req_we_i       = ~we;
    bus.req_size_i     = 2'b01;
    bus.req_unsigned_i = ~uns;
    bus.req_offset_i   = ~off;
    bus.req_rd_i       = ~rd;
    for (int i = 0; i < gd; i++) begin
      bus.data_rvalid_i = 1'($urandom);
      bus.data_rdata_i  = $urandom;
      #1 check("busy_wait_gnt", 32'(bus.busy_o), 32'd1);
      check("wb_quiet_gnt", 32'(bus.wb_valid_o), 32'd0);
      @(negedge clk);
    end
    bus.data_gnt_i    = 1'b1;
    bus.data_rvalid_i = 1'($urandom);
    #1 check("busy_gnt", 32'(bus.busy_o), 32'd1);
    check("wb_quiet_at_gnt", 32'(bus.wb_valid_o), 32'd0);
    @(negedge clk);
    bus.data_gnt_i    = 1'b0;
    bus.data_rvalid_i = 1'b0;
    for (int i = 0; i < rdly; i++) begin
      bus.data_rdata_i = $urandom;
      #1 check("busy_wait_rvalid", 32'(bus.busy_o), 32'd1);
      check("wb_quiet_rvalid", 32'(bus.wb_valid_o), 32'd0);
      @(negedge clk);
    end
    bus.data_rvalid_i = 1'b1;
    bus.data_rdata_i  = rdata;
    #1 check("busy_rvalid", 32'(bus.busy_o), 32'd1);
    @(negedge clk);
    bus.data_rvalid_i = 1'b0;
    bus.req_valid_i   = 1'b0;
    bus.data_rdata_i  = $urandom;
    if (!we) begin
      exp_rd   = rd;
      exp_data = model_load(size, uns, off, rdata);
    end
    #1 check("wb_valid", 32'(bus.wb_valid_o), 32'(!we));
    check("wb_rd", 32'(bus.wb_rd_o), 32'(exp_rd));
    check("wb_data", bus.wb_data_o, exp_data);
    check("busy_done", 32'(bus.busy_o), 32'd0);
    check("err_done", 32'(bus.err_o), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #2;
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check_idle_outputs("rst");
    // busy_o reflects a request being accepted even with the FSM idle.
    bus.req_valid_i = 1'b1;
    bus.req_size_i  = 2'b10;
    #1 check("rst_busy_req", 32'(bus.busy_o), 32'd1);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Size 00 is a no-op.
    bus.req_valid_i = 1'b1;
    bus.req_size_i  = 2'b00;
    #1 check("noop_busy", 32'(bus.busy_o), 32'd0);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    #1 check("noop_stays_idle", 32'(bus.busy_o), 32'd0);
    @(negedge clk);

    // Directed cases.
    txn(1'b0, 2'b01, 1'b0, 2'd2, 5'd5, 32'h1280_5678, 0, 0, 1'b0);   // LB
    @(negedge clk); #1 check("wb_one_cycle", 32'(bus.wb_valid_o), 32'd0);
    txn(1'b0, 2'b10, 1'b1, 2'd2, 5'd6, 32'h8001_1234, 0, 0, 1'b0);   // LHU
    txn(1'b0, 2'b10, 1'b0, 2'd0, 5'd7, 32'h0000_F00F, 1, 1, 1'b0);   // LH
    txn(1'b1, 2'b11, 1'b0, 2'd0, 5'd8, 32'hCAFE_F00D, 3, 2, 1'b1);   // SW
    txn(1'b0, 2'b11, 1'b0, 2'd0, 5'd9, 32'hDEAD_BEEF, 0, 0, 1'b0);   // LW
    txn(1'b0, 2'b11, 1'b1, 2'd1, 5'd10, 32'h0123_4567, 0, 0, 1'b0);  // back-to-back LW

    // Reset while waiting for rvalid; a late rvalid must be ignored.
    bus.req_valid_i = 1'b1;
    bus.req_size_i  = 2'b11;
    bus.req_rd_i    = 5'd17;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.data_gnt_i  = 1'b1;
    @(negedge clk);
    bus.data_gnt_i = 1'b0;
    #1 rst_n = 1'b0;
    exp_rd   = 5'd0;
    exp_data = 32'd0;
    #1 check("abort_busy", 32'(bus.busy_o), 32'd0);
    check_idle_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.data_rvalid_i = 1'b1;
    bus.data_rdata_i  = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.data_rvalid_i = 1'b0;
    #1 check("late_rvalid_busy", 32'(bus.busy_o), 32'd0);
    check_idle_outputs("late_rvalid");
    @(negedge clk);

    txn(1'b0, 2'b01, 1'b1, 2'd3, 5'd11, 32'hA5B6_C7D8, 0, 0, 1'b0);

    // No grant: watchdog fires after TimeoutCycles waiting cycles if enabled.
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_size_i  = 2'b11;
    bus.req_rd_i    = 5'd12;
    #1 check("to_busy_accept", 32'(bus.busy_o), 32'd1);
    for (int k = 0; k <= int'(TimeoutCycles) + 1; k++) begin
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      #1;
`ifdef LSU_LOAD_TIMEOUT_EN
      check("to_err", 32'(bus.err_o), 32'(k == int'(TimeoutCycles)));
      check("to_busy", 32'(bus.busy_o), 32'(k < int'(TimeoutCycles)));
`else
      check("to_err", 32'(bus.err_o), 32'd0);
      check("to_busy", 32'(bus.busy_o), 32'd1);
`endif
      check("to_wb_quiet", 32'(bus.wb_valid_o), 32'd0);
    end
    check("to_wb_data_kept", bus.wb_data_o, exp_data);
`ifndef LSU_LOAD_TIMEOUT_EN
    bus.data_gnt_i = 1'b1;
    @(negedge clk);
    bus.data_gnt_i    = 1'b0;
    bus.data_rvalid_i = 1'b1;
    bus.data_rdata_i  = 32'h7654_3210;
    @(negedge clk);
    bus.data_rvalid_i = 1'b0;
    exp_rd   = 5'd12;
    exp_data = 32'h7654_3210;
    #1 check("late_gnt_wb_valid", 32'(bus.wb_valid_o), 32'd1);
    check("late_gnt_wb_data", bus.wb_data_o, exp_data);
`endif
    txn(1'b0, 2'b10, 1'b0, 2'd3, 5'd13, 32'h9ABC_1357, 0, 0, 1'b0);

    // Randomized stream; wait lengths stay below the watchdog limit.
    for (int n = 0; n < 40; n++) begin
      txn(($urandom_range(0, 3) == 0), 2'($urandom_range(1, 3)), 1'($urandom),
          2'($urandom), 5'($urandom), $urandom, int'($urandom_range(0, 3)),
          int'($urandom_range(0, 2)), 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        #1 check("gap_idle", 32'(bus.busy_o), 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
